io_bus_timer_responder: RTL

- Responder (target) side of the 16-bit external IO bus driven by the system's Avalon-to-external-bus bridge.
- Signals: address, bus_enable, byte_enable, rw, write_data, read_data, acknowledge, irq.
- Decodes a small register window: scratch register, control register, down-counting timer with reload, and W1C status.
- Returns acknowledge after programmable wait states; raises irq on timer expiry.

---
 rtl/io_bus_timer_responder.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/io_bus_timer_responder.sv
// Target side of the 16-bit external IO bus: scratch, control, reloadable
// down-counting timer and W1C status, with programmable wait states and an expiry irq.
module io_bus_timer_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned PRESCALE    = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] io_address,
    input  logic        io_bus_enable,
    input  logic [1:0]  io_byte_enable,
    input  logic        io_rw,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        io_acknowledge,
    output logic        io_irq
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WAIT_W = 4;
    localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

    localparam logic [2:0] OFF_SCRATCH = 3'd0;
    localparam logic [2:0] OFF_CTRL    = 3'd1;
    localparam logic [2:0] OFF_RELOAD  = 3'd2;
    localparam logic [2:0] OFF_COUNT   = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WAIT_W-1:0] wait_cnt;
    logic [PRE_W-1:0]  prescaler;

    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] reload;
    logic [DATA_W-1:0] count;
    logic              ctrl_en;
    logic              ctrl_irq_en;
    logic              ctrl_auto;
    logic              expired;

    logic              hit_c;
    logic [2:0]        offset_c;
    logic              ack_set_c;
    logic              rd_latch_c;
    logic              wr_commit_c;
    logic              scratch_wr_c;
    logic              ctrl_wr_c;
    logic              reload_wr_c;
    logic              status_clr_c;
    logic              tick_c;
    logic              expire_c;
    logic [DATA_W-1:0] scratch_merged_c;
    logic [DATA_W-1:0] reload_merged_c;
    logic [DATA_W-1:0] read_mux_c;
    logic              unused_addr_lsb;

    // Replace only the byte lanes enabled for this write.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [1:0]        be
    );
        return {be[1] ? new_val[15:8] : old_val[15:8],
                be[0] ? new_val[7:0]  : old_val[7:0]};
    endfunction

    assign hit_c           = (io_address[15:4] == BASE_ADDR[15:4]);
    assign offset_c        = io_address[3:1];
    assign unused_addr_lsb = io_address[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A bus_enable drop while waiting aborts the transfer without side effects.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (io_bus_enable && hit_c) begin
                    state_next = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!io_bus_enable) begin
                    state_next = S_IDLE;
                end else if (wait_cnt <= WAIT_W'(1)) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                if (!io_bus_enable) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Read data is captured on the edge entering ACK so it is valid alongside the pulse.
    always_comb begin
        ack_set_c   = 1'b0;
        rd_latch_c  = 1'b0;
        wr_commit_c = 1'b0;
        if (state_next == S_ACK) begin
            ack_set_c  = 1'b1;
            rd_latch_c = io_rw;
        end
        if (state == S_ACK) begin
            wr_commit_c = ~io_rw;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_IDLE) begin
            wait_cnt <= WAIT_INIT;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    assign scratch_merged_c = merge_lanes(scratch, io_write_data, io_byte_enable);
    assign reload_merged_c  = merge_lanes(reload, io_write_data, io_byte_enable);

    assign scratch_wr_c = wr_commit_c && (offset_c == OFF_SCRATCH);
    assign ctrl_wr_c    = wr_commit_c && (offset_c == OFF_CTRL) && io_byte_enable[0];
    assign reload_wr_c  = wr_commit_c && (offset_c == OFF_RELOAD) && (io_byte_enable != 2'b00);
    assign status_clr_c = wr_commit_c && (offset_c == OFF_STATUS) && io_byte_enable[0]
                          && io_write_data[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch <= '0;
        end else if (scratch_wr_c) begin
            scratch <= scratch_merged_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload <= '0;
        end else if (reload_wr_c) begin
            reload <= reload_merged_c;
        end
    end

    // A bus write to CTRL takes priority over the one-shot hardware disable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_auto   <= 1'b0;
        end else if (ctrl_wr_c) begin
            ctrl_en     <= io_write_data[0];
            ctrl_irq_en <= io_write_data[1];
            ctrl_auto   <= io_write_data[2];
        end else if (expire_c && !ctrl_auto) begin
            ctrl_en <= 1'b0;
        end
    end

    assign tick_c   = ctrl_en && (prescaler == PRE_LAST);
    assign expire_c = tick_c && (count == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (!ctrl_en || (prescaler == PRE_LAST)) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // A RELOAD write reloads COUNT and discards a coincident tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (reload_wr_c) begin
            count <= reload_merged_c;
        end else if (tick_c) begin
            if (count != '0) begin
                count <= count - DATA_W'(1);
            end else if (ctrl_auto) begin
                count <= reload;
            end
        end
    end

    // Expiry wins over a coincident W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expired <= 1'b0;
        end else if (expire_c) begin
            expired <= 1'b1;
        end else if (status_clr_c) begin
            expired <= 1'b0;
        end
    end

    always_comb begin
        read_mux_c = '0;
        case (offset_c)
            OFF_SCRATCH: read_mux_c = scratch;
            OFF_CTRL:    read_mux_c = {13'b0, ctrl_auto, ctrl_irq_en, ctrl_en};
            OFF_RELOAD:  read_mux_c = reload;
            OFF_COUNT:   read_mux_c = count;
            OFF_STATUS:  read_mux_c = {15'b0, expired};
            default:     read_mux_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_acknowledge <= 1'b0;
            io_read_data   <= '0;
            io_irq         <= 1'b0;
        end else begin
            io_acknowledge <= ack_set_c;
            if (rd_latch_c) begin
                io_read_data <= read_mux_c;
            end
            io_irq <= expired & ctrl_irq_en;
        end
    end

endmodule
